// File: rtl/sign_ext_pkg.sv
// rtl/sign_ext_pkg.sv - shared immediate-extension mode encodings and default widths
package sign_ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_SHL2  = 2'b10,
        EXT_UPPER = 2'b11
    } ext_mode_e;

    localparam int IMM_W  = 8;
    localparam int WORD_W = 16;

endpackage

// File: rtl/sign_ext_core.sv
// rtl/sign_ext_core.sv - combinational immediate extender (extra modes under SIGNEXT_MODES_EN)
module sign_ext_core
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  a,
    output logic [OUT_W-1:0] y,
    output logic             neg
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    assign sext = {{EXT_W{a[IN_W-1]}}, a};
    assign neg  = a[IN_W-1];

`ifdef SIGNEXT_MODES_EN
    // Mode decode; unknown or unlisted encodings fall back to sign-extend
    always_comb begin
        y = sext;
        case (mode)
            EXT_ZERO:  y = {{EXT_W{1'b0}}, a};
            EXT_SHL2:  y = {sext[OUT_W-3:0], 2'b00};
            EXT_UPPER: y = {a, {EXT_W{1'b0}}};
            default:   y = sext;
        endcase
    end
`else
    // Mode port is kept for a uniform interface but has no effect here
    logic unused_mode;
    assign unused_mode = ^mode;
    assign y = sext;
`endif

endmodule

// File: rtl/sign_ext.sv
// rtl/sign_ext.sv - immediate extender with clock-enabled capture register (SIGNEXT_MODES_EN selects full mode set)
module sign_ext
    import sign_ext_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  a,
    output logic [OUT_W-1:0] y,
    output logic             neg,
    output logic [OUT_W-1:0] y_q,
    output logic             neg_q,
    output logic             vld_q
);

    sign_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode (mode),
        .a    (a),
        .y    (y),
        .neg  (neg)
    );

    // Capture the extended value for later FSM cycles; vld_q pulses per capture
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q   <= '0;
            neg_q <= 1'b0;
            vld_q <= 1'b0;
        end else if (en) begin
            y_q   <= y;
            neg_q <= neg;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sign_ext.sv
// tb/tb_sign_ext.sv - self-checking bench for sign_ext with directed and random stimulus
module tb_sign_ext;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  a;
    logic [15:0] y;
    logic        neg;
    logic [15:0] y_q;
    logic        neg_q;
    logic        vld_q;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_yq;
    logic        exp_nq;
    logic        exp_vq;

    sign_ext #(.IN_W(8), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .a     (a),
        .y     (y),
        .neg   (neg),
        .y_q   (y_q),
        .neg_q (neg_q),
        .vld_q (vld_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: treat the immediate as a signed integer and apply the arithmetic rule
    function automatic logic [15:0] model_y(input logic [1:0] m, input logic [7:0] v);
        int s;
        logic [1:0] mm;
        s  = (v >= 8'd128) ? int'(v) - 256 : int'(v);
        mm = m;
`ifndef SIGNEXT_MODES_EN
        mm = 2'b00;
`endif
        case (mm)
            2'b01:   return 16'(int'(v));
            2'b10:   return 16'(s * 4);
            2'b11:   return 16'(int'(v) * 256);
            default: return 16'(s);
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        #1;
        check({tag, "_y"}, y, model_y(mode, a));
        check({tag, "_neg"}, {15'd0, neg}, {15'd0, a[7]});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            exp_yq = '0; exp_nq = 1'b0; exp_vq = 1'b0;
        end else if (en) begin
            exp_yq = model_y(mode, a); exp_nq = a[7]; exp_vq = 1'b1;
        end else begin
            exp_vq = 1'b0;
        end
        #1;
        check({tag, "_yq"}, y_q, exp_yq);
        check({tag, "_nq"}, {15'd0, neg_q}, {15'd0, exp_nq});
        check({tag, "_vq"}, {15'd0, vld_q}, {15'd0, exp_vq});
    endtask

    initial begin
        exp_yq = '0; exp_nq = 1'b0; exp_vq = 1'b0;
        reset = 1'b1; en = 1'b0; mode = 2'b00; a = 8'h00;
        tick("reset0");
        check("reset_yq_zero", y_q, 16'h0000);

        // Directed combinational cases
        reset = 1'b0;
        mode = 2'b00; a = 8'hF3; check_comb("sx_f3");
        check("sx_f3_const", y, 16'hFFF3);
        a = 8'h4F; check_comb("sx_4f");
        check("sx_4f_const", y, 16'h004F);
        mode = 2'b01; a = 8'hF3; check_comb("zx_f3");
`ifdef SIGNEXT_MODES_EN
        check("zx_f3_const", y, 16'h00F3);
`else
        check("nomodes_f3_const", y, 16'hFFF3);
`endif
        mode = 2'b11; a = 8'h4F; check_comb("up_4f");
        mode = 2'b10; a = 8'hF3; check_comb("sh_f3");
        a = 8'h4F; check_comb("sh_4f");
        a = 8'h80; check_comb("sh_80");
        mode = 2'bxx; a = 8'h91; check_comb("modex");
        check("modex_const", y, 16'hFF91);

        // Reset for one edge, then capture
        reset = 1'b1; en = 1'b1; mode = 2'b00; a = 8'hF3;
        tick("rst_en");
        reset = 1'b0;
        tick("cap1");
        check("cap1_const", y_q, 16'hFFF3);

        // Drop enable, change input: register holds, comb output follows
        en = 1'b0; a = 8'h4F;
        check_comb("hold_comb");
        check("hold_y_const", y, 16'h004F);
        tick("hold");
        check("hold_yq_const", y_q, 16'hFFF3);

        // Back-to-back captures keep vld_q high
        en = 1'b1; a = 8'h12; tick("b2b0");
        a = 8'h85; tick("b2b1");
        a = 8'h7E; tick("b2b2");

        // Reset mid-operation discards the pending capture
        reset = 1'b1; a = 8'hAA; tick("rst_mid");
        reset = 1'b0;

        // Random stimulus
        for (int i = 0; i < 300; i++) begin
            a     = 8'($urandom);
            mode  = 2'($urandom);
            en    = 1'($urandom);
            reset = ($urandom_range(0, 15) == 0);
            check_comb("rnd");
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
